// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 default timing, count width and sequencer states
package vga_pkg;

  localparam int CW = 10;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one scan axis: wrapping position count with active/sync region decode
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int TOTAL  = 800,
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          ce,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          active,
  output logic          sync_region
);

  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

  assign wrap        = ce && (count == LAST);
  assign active      = int'(count) < ACTIVE;
  // Compared in int so ACTIVE+FP+SYNC reaching 1024 cannot alias to zero
  assign sync_region = (int'(count) >= ACTIVE + FP) && (int'(count) < ACTIVE + FP + SYNC);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (ce) begin
      count <= wrap ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - pixel-enable divider, h/v scan sequencing and registered sync/blank decode
module vga_timing_ctrl #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter int CLK_DIV  = 4,
  parameter bit SYNC_ACT = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  output logic                   running,
  output logic                   pix_ce,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   video_on,
  output logic [vga_pkg::CW-1:0] x,
  output logic [vga_pkg::CW-1:0] y,
  output logic                   line_start,
  output logic                   frame_start
);

  localparam int CW      = vga_pkg::CW;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  vga_pkg::state_t state, state_nx;
  logic [DW-1:0]   div;
  logic            idle, tick;
  logic [CW-1:0]   h, v;
  logic            h_wrap, v_wrap, h_act, v_act, h_syn, v_syn;

  assign idle    = (state == vga_pkg::ST_IDLE);
  assign tick    = !idle && (div == DIV_LAST);
  assign running = !idle;

  always_ff @(posedge clk) begin
    if (rst) state <= vga_pkg::ST_IDLE;
    else     state <= state_nx;
  end

  // run is honoured ahead of the end-of-frame check, so a re-request in the last tick keeps scanning
  always_comb begin
    state_nx = state;
    case (state)
      vga_pkg::ST_IDLE:  if (run) state_nx = vga_pkg::ST_RUN;
      vga_pkg::ST_RUN:   if (!run) state_nx = vga_pkg::ST_DRAIN;
      vga_pkg::ST_DRAIN: begin
        if (run)                   state_nx = vga_pkg::ST_RUN;
        else if (h_wrap && v_wrap) state_nx = vga_pkg::ST_IDLE;
      end
      default:           state_nx = vga_pkg::ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || idle || tick) div <= '0;
    else                     div <= div + DW'(1);
  end

  vga_axis_counter #(.TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC)) u_h (
    .clk(clk), .rst(rst), .clr(idle), .ce(tick),
    .count(h), .wrap(h_wrap), .active(h_act), .sync_region(h_syn)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC)) u_v (
    .clk(clk), .rst(rst), .clr(idle), .ce(h_wrap),
    .count(v), .wrap(v_wrap), .active(v_act), .sync_region(v_syn)
  );

  // Outputs capture the position at its tick, so each value appears together with its pix_ce pulse
  always_ff @(posedge clk) begin
    if (rst || idle) begin
      pix_ce      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      video_on    <= 1'b0;
      hsync       <= !SYNC_ACT;
      vsync       <= !SYNC_ACT;
      x           <= '0;
      y           <= '0;
    end else begin
      pix_ce      <= tick;
      line_start  <= tick && (h == '0);
      frame_start <= tick && (h == '0) && (v == '0);
      if (tick) begin
        x        <= h;
        y        <= v;
        video_on <= h_act && v_act;
        hsync    <= h_syn ? SYNC_ACT : !SYNC_ACT;
        vsync    <= v_syn ? SYNC_ACT : !SYNC_ACT;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb/tb_vga_timing_ctrl.sv - reduced-geometry scan check of two divider/polarity variants against a pixel-index model
module tb_vga_timing_ctrl;

  localparam int HA = 8, HFP = 2, HSW = 3, HBP = 2, HT = HA + HFP + HSW + HBP;
  localparam int VA = 6, VFP = 1, VSW = 2, VBP = 1, VT = VA + VFP + VSW + VBP;

  typedef struct packed {
    logic       running;
    logic       pix_ce;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] x;
    logic [9:0] y;
    logic       line_start;
    logic       frame_start;
  } vo_t;

  logic clk = 1'b0, rst = 1'b1, run = 1'b1;
  logic running [2], pix_ce [2], hsync [2], vsync [2], video_on [2], line_start [2], frame_start [2];
  logic [9:0] x [2], y [2];

  int divs [2] = '{3, 1};
  bit sacts [2] = '{1'b0, 1'b1};

  int total = 0, bad = 0, cyc = 0;
  bit chk_en = 1'b0;

  vo_t exp_o [2], got_o [2];
  bit  m_act [2], m_drain [2];
  int  m_phase [2];
  int  n_m, px, py;

  int pix_cnt [2] = '{0, 0}, last_fs [2] = '{-1, -1}, fs_period [2] = '{-1, -1};
  int last_ls_pix [2] = '{-1, -1}, line_len [2] = '{-1, -1};

  always #5 clk = ~clk;

  vga_timing_ctrl #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
                    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
                    .CLK_DIV(3), .SYNC_ACT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .run(run), .running(running[0]), .pix_ce(pix_ce[0]),
    .hsync(hsync[0]), .vsync(vsync[0]), .video_on(video_on[0]), .x(x[0]), .y(y[0]),
    .line_start(line_start[0]), .frame_start(frame_start[0])
  );

  vga_timing_ctrl #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
                    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
                    .CLK_DIV(1), .SYNC_ACT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .run(run), .running(running[1]), .pix_ce(pix_ce[1]),
    .hsync(hsync[1]), .vsync(vsync[1]), .video_on(video_on[1]), .x(x[1]), .y(y[1]),
    .line_start(line_start[1]), .frame_start(frame_start[1])
  );

  always_comb begin
    for (int i = 0; i < 2; i++)
      got_o[i] = {running[i], pix_ce[i], hsync[i], vsync[i], video_on[i], x[i], y[i],
                  line_start[i], frame_start[i]};
  end

  function automatic vo_t idle_out(bit sa, bit rn);
    vo_t o;
    o = '0;
    o.running = rn;
    o.hsync   = !sa;
    o.vsync   = !sa;
    return o;
  endfunction

  // Model: the n-th pixel since scan start appears n*div+div clks in; position is n mod the frame geometry
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_act[i] = 1'b0;
        exp_o[i] = idle_out(sacts[i], 1'b0);
      end else if (!m_act[i]) begin
        exp_o[i] = idle_out(sacts[i], run);
        if (run) begin
          m_act[i] = 1'b1;
          m_phase[i] = 0;
          m_drain[i] = 1'b0;
        end
      end else begin
        m_phase[i]++;
        if (m_phase[i] % divs[i] == 0) begin
          n_m = m_phase[i] / divs[i] - 1;
          px = n_m % HT;
          py = (n_m / HT) % VT;
          exp_o[i].pix_ce      = 1'b1;
          exp_o[i].x           = 10'(px);
          exp_o[i].y           = 10'(py);
          exp_o[i].video_on    = (px < HA) && (py < VA);
          exp_o[i].hsync       = (px >= HA + HFP && px < HA + HFP + HSW) ? sacts[i] : !sacts[i];
          exp_o[i].vsync       = (py >= VA + VFP && py < VA + VFP + VSW) ? sacts[i] : !sacts[i];
          exp_o[i].line_start  = (px == 0);
          exp_o[i].frame_start = (px == 0) && (py == 0);
          if (px == HT - 1 && py == VT - 1 && m_drain[i] && !run) m_act[i] = 1'b0;
        end else begin
          exp_o[i].pix_ce      = 1'b0;
          exp_o[i].line_start  = 1'b0;
          exp_o[i].frame_start = 1'b0;
        end
        m_drain[i] = !run;
        exp_o[i].running = m_act[i];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        total++;
        if (got_o[i] !== exp_o[i]) begin
          bad++;
          $display("FAIL outputs dut%0d cyc=%0d got=%h want=%h", i, cyc, got_o[i], exp_o[i]);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (pix_ce[i]) pix_cnt[i]++;
      if (!running[i]) begin
        last_fs[i] = -1;
        last_ls_pix[i] = -1;
      end else begin
        if (frame_start[i]) begin
          if (last_fs[i] >= 0) fs_period[i] = cyc - last_fs[i];
          last_fs[i] = cyc;
        end
        if (line_start[i]) begin
          if (last_ls_pix[i] >= 0) line_len[i] = pix_cnt[i] - last_ls_pix[i];
          last_ls_pix[i] = pix_cnt[i];
        end
      end
    end
  end

  task automatic check(input string nm, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  int g, first_run, first_fs0, first_fs1, p0;

  initial begin
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hsync0", hsync[0], 1);
    check("rst_vsync0", vsync[0], 1);
    check("rst_hsync1", hsync[1], 0);
    check("rst_video0", video_on[0], 0);
    check("rst_xy0", {x[0], y[0]}, 0);
    check("rst_running0", running[0], 0);

    rst = 1'b0;
    first_run = -1; first_fs0 = -1; first_fs1 = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (running[0] && first_run < 0) first_run = k;
      if (frame_start[0] && first_fs0 < 0) first_fs0 = k;
      if (frame_start[1] && first_fs1 < 0) first_fs1 = k;
    end
    check("first_running", first_run, 1);
    check("first_fs_div3", first_fs0, 4);
    check("first_fs_div1", first_fs1, 2);

    repeat (1000) @(negedge clk);
    check("frame_period_div3", fs_period[0], 450);
    check("frame_period_div1", fs_period[1], 150);
    check("line_pix_div3", line_len[0], 15);
    check("line_pix_div1", line_len[1], 15);

    g = 0;
    while (y[0] != 10'd3 && g < 600) begin @(negedge clk); g++; end
    check("reach_y3", int'(g < 600), 1);
    run = 1'b0;
    g = 0;
    while (running[0] && g < 600) begin @(negedge clk); g++; end
    check("drain_done", int'(g < 600), 1);
    check("drain_last_x", x[0], HT - 1);
    check("drain_last_y", y[0], VT - 1);
    @(negedge clk);
    check("idle_x", x[0], 0);
    check("idle_hsync", hsync[0], 1);
    repeat (10) @(negedge clk);

    run = 1'b1;
    g = 0;
    while (y[0] != 10'd2 && g < 600) begin @(negedge clk); g++; end
    run = 1'b0;
    while (y[0] != 10'd5 && g < 600) begin @(negedge clk); g++; end
    run = 1'b1;
    while (!frame_start[0] && g < 1200) begin @(negedge clk); g++; end
    #1;
    check("reassert_in_drain", int'(g < 1200), 1);
    check("reassert_period", fs_period[0], 450);

    @(negedge clk);
    g = 0;
    while (!(x[0] == 10'd5 && y[0] == 10'd4 && pix_ce[0]) && g < 600) begin @(negedge clk); g++; end
    check("reach_abort_point", int'(g < 600), 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_running", running[0], 0);
    check("abort_pix_ce", pix_ce[0], 0);
    check("abort_x", x[0], 0);
    rst = 1'b0;
    run = 1'b0;
    p0 = pix_cnt[0] + pix_cnt[1];
    repeat (30) @(negedge clk);
    check("no_pix_after_abort", pix_cnt[0] + pix_cnt[1] - p0, 0);

    run = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if ($urandom_range(299) == 0) run = !run;
      rst = ($urandom_range(1499) == 0);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
